// File: rtl/rat_pkg.sv
// Constants shared across the RAT MCU datapath, plus the call-stack operation decode type.
package rat_pkg;

    localparam int unsigned PC_WIDTH         = 10;
    localparam int unsigned STACK_DEPTH_LOG2 = 8;
    localparam logic [PC_WIDTH-1:0] PC_IRQ_VECTOR = 10'h3FF;

    // One decoded action per clock edge; error cases get their own codes so flag logic stays flat.
    typedef enum logic [2:0] {
        OpNone,
        OpLoad,
        OpPush,
        OpPop,
        OpReplace,
        OpOvf,
        OpUnf
    } stack_op_e;

endpackage

// File: rtl/pc_stack_if.sv
// Control/status bundle between the RAT control unit (master) and the call stack (slave).
interface pc_stack_if
    import rat_pkg::*;
#(
    parameter int unsigned Width     = PC_WIDTH,
    parameter int unsigned DepthLog2 = STACK_DEPTH_LOG2
);

    logic                 push;
    logic                 pop;
    logic [Width-1:0]     din;
    logic                 sp_ld;
    logic [DepthLog2-1:0] sp_din;
    logic [Width-1:0]     from_stack;
    logic [DepthLog2-1:0] sp_out;
    logic                 full;
    logic                 empty;
    logic                 ovf;
    logic                 unf;

    modport master (
        output push, pop, din, sp_ld, sp_din,
        input  from_stack, sp_out, full, empty, ovf, unf
    );

    modport slave (
        input  push, pop, din, sp_ld, sp_din,
        output from_stack, sp_out, full, empty, ovf, unf
    );

endinterface

// File: rtl/pc_stack_ram.sv
// Stack storage: synchronous write, asynchronous read so the top entry is visible with no latency.
module pc_stack_ram #(
    parameter int unsigned Width     = 10,
    parameter int unsigned DepthLog2 = 8
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [DepthLog2-1:0] waddr_i,
    input  logic [Width-1:0]     wdata_i,
    input  logic [DepthLog2-1:0] raddr_i,
    output logic [Width-1:0]     rdata_o
);

    localparam int unsigned Depth = 2 ** DepthLog2;

    logic [Width-1:0] mem_q [Depth];

    // Contents survive reset; only the pointer and occupancy are cleared.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pc_stack.sv
// Hardware call/return stack: down-growing SP, occupancy count, sticky overflow/underflow flags.
module pc_stack
    import rat_pkg::*;
#(
    parameter int unsigned Width     = PC_WIDTH,
    parameter int unsigned DepthLog2 = STACK_DEPTH_LOG2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    pc_stack_if.slave  bus
);

    localparam int unsigned CntW = DepthLog2 + 1;

    typedef logic [DepthLog2-1:0] sp_t;
    typedef logic [CntW-1:0]      cnt_t;

    localparam cnt_t CntFull = cnt_t'(2 ** DepthLog2);
    localparam cnt_t CntOne  = cnt_t'(1);
    localparam sp_t  SpOne   = sp_t'(1);

    sp_t       sp_q, sp_d;
    cnt_t      cnt_q, cnt_d;
    logic      ovf_q, ovf_d;
    logic      unf_q, unf_d;
    logic      full, empty;
    logic      ram_we;
    sp_t       ram_waddr;
    stack_op_e op;

    assign full  = (cnt_q == CntFull);
    assign empty = (cnt_q == '0);

    // Empty check precedes the push/pop pairing so PUSH+POP on empty counts as an underflow.
    always_comb begin
        op = OpNone;
        if (bus.sp_ld) begin
            op = OpLoad;
        end else if (bus.pop && empty) begin
            op = OpUnf;
        end else if (bus.push && bus.pop) begin
            op = OpReplace;
        end else if (bus.push && full) begin
            op = OpOvf;
        end else if (bus.push) begin
            op = OpPush;
        end else if (bus.pop) begin
            op = OpPop;
        end
    end

    always_comb begin
        sp_d      = sp_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        ram_we    = 1'b0;
        ram_waddr = sp_q - SpOne;
        unique case (op)
            OpLoad: begin
                sp_d  = bus.sp_din;
                // Occupancy implied by a loaded SP; SP=0 is taken as an empty stack.
                cnt_d = (bus.sp_din == '0) ? '0 : CntFull - cnt_t'(bus.sp_din);
            end
            OpPush: begin
                ram_we = 1'b1;
                sp_d   = sp_q - SpOne;
                cnt_d  = cnt_q + CntOne;
            end
            OpPop: begin
                sp_d  = sp_q + SpOne;
                cnt_d = cnt_q - CntOne;
            end
            OpReplace: begin
                ram_we    = 1'b1;
                ram_waddr = sp_q;
            end
            OpOvf:   ovf_d = 1'b1;
            OpUnf:   unf_d = 1'b1;
            OpNone:  ;
            default: ;
        endcase
        if (rst_i) begin
            ram_we = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    pc_stack_ram #(
        .Width     (Width),
        .DepthLog2 (DepthLog2)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (bus.din),
        .raddr_i (sp_q),
        .rdata_o (bus.from_stack)
    );

    assign bus.sp_out = sp_q;
    assign bus.full   = full;
    assign bus.empty  = empty;
    assign bus.ovf    = ovf_q;
    assign bus.unf    = unf_q;

endmodule
